// File: rtl/alu2_fwd_stage.sv
// alu2_fwd_stage: registered ALU operand-2 stage.
// Chooses rs2 data or the immediate for ALU operand 2. Forwarded results override rs2.
// When the matching producer is still pending (load-use), the stage holds the entry until
// that result arrives. Valid/ready handshakes are used on both sides.
// Optional feature: define ALU2_FWD_STATS_EN to add the fwd_cnt and stall_cnt counter outputs.
module alu2_fwd_stage #(
  parameter int XLEN    = 32,  // REG_LEN
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       alu2_sel,
  input  logic [RADDR_W-1:0]         rs2_addr,
  input  logic [XLEN-1:0]            rs2_d,
  input  logic [XLEN-1:0]            imm,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD-1:0]         fwd_pending,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            alu_in2,
  output logic                       out_fwd
`ifdef ALU2_FWD_STATS_EN
  ,
  output logic [31:0]                fwd_cnt,
  output logic [31:0]                stall_cnt
`endif
);

  // Select encoding: 0 selects rs2, 1 selects the immediate.
  localparam logic ALU2_IMM = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state_reg;
  logic               out_valid_reg;
  logic [XLEN-1:0]    alu_in2_reg;
  logic               out_fwd_reg;
  logic               hold_sel_reg;
  logic [RADDR_W-1:0] hold_addr_reg;
  logic [XLEN-1:0]    hold_d_reg;

  logic [NUM_FWD-1:0] in_match;
  logic [NUM_FWD-1:0] hold_match;

  // Per-slot match flags for the incoming entry and for the held entry.
  // Register 0 is hard-wired to zero, so it never forwards.
  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
      assign in_match[gi]   = fwd_valid[gi]
                              && (fwd_rd[gi*RADDR_W +: RADDR_W] == rs2_addr)
                              && (rs2_addr != '0);
      assign hold_match[gi] = fwd_valid[gi]
                              && (fwd_rd[gi*RADDR_W +: RADDR_W] == hold_addr_reg)
                              && (hold_addr_reg != '0);
    end
  endgenerate

  logic            in_hit, in_pend, hold_hit, hold_pend;
  logic [XLEN-1:0] in_fdata, hold_fdata;

  // Priority pick: the lowest matching index (youngest source) wins, even if it is pending.
  always_comb begin
    in_hit     = 1'b0;
    in_pend    = 1'b0;
    in_fdata   = '0;
    hold_hit   = 1'b0;
    hold_pend  = 1'b0;
    hold_fdata = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (in_match[i]) begin
        in_hit   = 1'b1;
        in_pend  = fwd_pending[i];
        in_fdata = fwd_data[i*XLEN +: XLEN];
      end
      if (hold_match[i]) begin
        hold_hit   = 1'b1;
        hold_pend  = fwd_pending[i];
        hold_fdata = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  logic            in_ok, in_fwd, hold_ok, hold_fwd;
  logic [XLEN-1:0] in_val, hold_val;

  // Resolve the operand for the incoming entry and for the held entry.
  always_comb begin
    in_ok    = (alu2_sel == ALU2_IMM) || !in_hit || !in_pend;
    in_fwd   = (alu2_sel != ALU2_IMM) && in_hit;
    in_val   = (alu2_sel == ALU2_IMM) ? imm : (in_hit ? in_fdata : rs2_d);
    hold_ok  = (hold_sel_reg == ALU2_IMM) || !hold_hit || !hold_pend;
    hold_fwd = (hold_sel_reg != ALU2_IMM) && hold_hit;
    hold_val = (hold_sel_reg == ALU2_IMM) ? hold_d_reg : (hold_hit ? hold_fdata : hold_d_reg);
  end

  logic accept;
  assign in_ready = !rst && !flush
                    && ((state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Stage FSM with registered outputs: IDLE -> (DONE | WAIT), WAIT -> DONE, DONE -> IDLE/accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      out_valid_reg <= 1'b0;
      alu_in2_reg   <= '0;
      out_fwd_reg   <= 1'b0;
      hold_sel_reg  <= 1'b0;
      hold_addr_reg <= '0;
      hold_d_reg    <= '0;
    end else if (flush) begin
      state_reg     <= S_IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_WAIT: begin
          if (hold_ok) begin
            state_reg     <= S_DONE;
            out_valid_reg <= 1'b1;
            alu_in2_reg   <= hold_val;
            out_fwd_reg   <= hold_fwd;
          end
        end
        S_DONE: begin
          if (out_ready && !in_valid) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
      // A new entry may arrive from IDLE or back-to-back from DONE.
      if (accept) begin
        if (in_ok) begin
          state_reg     <= S_DONE;
          out_valid_reg <= 1'b1;
          alu_in2_reg   <= in_val;
          out_fwd_reg   <= in_fwd;
        end else begin
          state_reg     <= S_WAIT;
          out_valid_reg <= 1'b0;
          hold_sel_reg  <= alu2_sel;
          hold_addr_reg <= rs2_addr;
          hold_d_reg    <= rs2_d;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign alu_in2   = alu_in2_reg;
  assign out_fwd   = out_fwd_reg;

`ifdef ALU2_FWD_STATS_EN
  logic [31:0] fwd_cnt_reg;
  logic [31:0] stall_cnt_reg;

  // Saturating statistics: forwarded hand-offs and WAIT cycles; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (out_valid_reg && out_ready && out_fwd_reg && (fwd_cnt_reg != 32'hFFFF_FFFF))
        fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
      if ((state_reg == S_WAIT) && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign fwd_cnt   = fwd_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_alu2_fwd_stage.sv
// Testbench for alu2_fwd_stage: directed scenarios plus randomized traffic.
// Every cycle, DUT outputs are compared against a transaction-level reference model.
module tb_alu2_fwd_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, alu2_sel, out_valid, out_ready, out_fwd;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_d, imm, alu_in2;
  logic [1:0]  fwd_valid, fwd_pending;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
`ifdef ALU2_FWD_STATS_EN
  logic [31:0] fwd_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  alu2_fwd_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu2_sel(alu2_sel), .rs2_addr(rs2_addr), .rs2_d(rs2_d), .imm(imm),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_in2(alu_in2), .out_fwd(out_fwd)
`ifdef ALU2_FWD_STATS_EN
    , .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one entry in flight, either awaiting a result or ready for hand-off.
  bit          m_busy, m_ready;
  logic [4:0]  m_addr;
  logic [31:0] m_d, m_val;
  bit          m_fwd;
  longint      m_fwd_cnt, m_stall_cnt;

  // Compute the operand from the live forwarding inputs; ok=0 means the youngest match is pending.
  task automatic resolve(input bit sel, input logic [4:0] addr, input logic [31:0] d,
                         input logic [31:0] im, output bit ok, output logic [31:0] v,
                         output bit f);
    ok = 1; v = d; f = 0;
    if (sel) begin
      v = im;
      return;
    end
    if (addr == 0) return;
    for (int i = 0; i < 2; i++) begin
      if (fwd_valid[i] && fwd_rd[i*5 +: 5] == addr) begin
        ok = !fwd_pending[i];
        v  = fwd_data[i*32 +: 32];
        f  = 1;
        return;
      end
    end
  endtask

  // Compare outputs in the middle of the cycle, advance the model, then move to the next cycle.
  task automatic step();
    bit          exp_rdy, take, ok, f;
    logic [31:0] v;
    #2;
    exp_rdy = !rst && !flush && (!m_busy || (m_ready && out_ready));
    check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_val("out_valid", {31'd0, out_valid}, {31'd0, m_busy && m_ready});
    if (m_busy && m_ready) begin
      check_val("alu_in2", alu_in2, m_val);
      check_val("out_fwd", {31'd0, out_fwd}, {31'd0, m_fwd});
    end
`ifdef ALU2_FWD_STATS_EN
    check_val("fwd_cnt", fwd_cnt, m_fwd_cnt[31:0]);
    check_val("stall_cnt", stall_cnt, m_stall_cnt[31:0]);
`endif
    if (m_busy && m_ready && out_ready && !rst)
      $display("xfer alu_in2=%h out_fwd=%0d flush=%0d", m_val, m_fwd, flush);
    take = in_valid && exp_rdy;
    if (rst) begin
      m_busy = 0; m_ready = 0; m_fwd_cnt = 0; m_stall_cnt = 0;
    end else begin
      if (m_busy && !m_ready) m_stall_cnt++;
      if (m_busy && m_ready && out_ready && m_fwd) m_fwd_cnt++;
      if (flush) begin
        m_busy = 0;
      end else begin
        if (m_busy && !m_ready) begin
          resolve(1'b0, m_addr, m_d, 32'd0, ok, v, f);
          if (ok) begin m_ready = 1; m_val = v; m_fwd = f; end
        end else if (m_busy && m_ready && out_ready) begin
          m_busy = 0;
        end
        if (take) begin
          resolve(alu2_sel, rs2_addr, rs2_d, imm, ok, v, f);
          m_busy = 1; m_ready = ok;
          if (ok) begin m_val = v; m_fwd = f; end
          else begin m_addr = rs2_addr; m_d = rs2_d; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; flush = 0; in_valid = 0; alu2_sel = 0; rs2_addr = 0; rs2_d = 0; imm = 0;
    fwd_valid = 0; fwd_pending = 0; fwd_rd = 0; fwd_data = 0; out_ready = 1;
  endtask

  longint st0;

  initial begin
    quiet();
    rst = 1; in_valid = 1; alu2_sel = 1; imm = 32'h55;
    m_busy = 0; m_ready = 0; m_fwd_cnt = 0; m_stall_cnt = 0; m_val = 0; m_fwd = 0;
    m_addr = 0; m_d = 0;
    @(posedge clk); #1;
    step();
    // Reset with in_valid asserted: nothing accepted, outputs zero.
    rst = 0; in_valid = 0;
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_alu_in2", alu_in2, 32'd0);
    check_val("rst_fwd", {31'd0, out_fwd}, 32'd0);

    // IMM path ignores a matching forward slot.
    quiet(); in_valid = 1; alu2_sel = 1; imm = 32'h0000_0123; rs2_addr = 3;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd3}; fwd_data = {32'd0, 32'h999};
    step(); in_valid = 0;
    check_val("imm_valid", {31'd0, out_valid}, 32'd1);
    check_val("imm_val", alu_in2, 32'h123);
    check_val("imm_fwd", {31'd0, out_fwd}, 32'd0);
    step();

    // Priority: both slots match, the youngest wins.
    quiet(); in_valid = 1; rs2_addr = 5; fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5};
    fwd_data = {32'hBB, 32'hAA};
    step(); in_valid = 0;
    check_val("prio_val", alu_in2, 32'hAA);
    check_val("prio_fwd", {31'd0, out_fwd}, 32'd1);
    step();

    // Load-use: slot0 pending for three cycles, then the result arrives.
    st0 = m_stall_cnt;
    quiet(); in_valid = 1; rs2_addr = 7; rs2_d = 32'h1111; fwd_valid = 2'b01;
    fwd_pending = 2'b01; fwd_rd = {5'd0, 5'd7};
    step(); in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      check_val("lu_wait_rdy", {31'd0, in_ready}, 32'd0);
      step();
    end
    fwd_pending = 0; fwd_data = {32'd0, 32'hDEAD_BEEF};
    check_val("lu_wait_rdy", {31'd0, in_ready}, 32'd0);
    step();
    check_val("lu_valid", {31'd0, out_valid}, 32'd1);
    check_val("lu_val", alu_in2, 32'hDEAD_BEEF);
    check_val("lu_stalls", 32'(m_stall_cnt - st0), 32'd3);
    step();

    // x0 is never forwarded.
    quiet(); in_valid = 1; rs2_addr = 0; rs2_d = 0; fwd_valid = 2'b01; fwd_rd = 0;
    fwd_data = {32'd0, 32'hFFFF_FFFF};
    step(); in_valid = 0;
    check_val("x0_val", alu_in2, 32'd0);
    check_val("x0_fwd", {31'd0, out_fwd}, 32'd0);
    step();

    // Backpressure then back-to-back hand-off.
    quiet(); in_valid = 1; alu2_sel = 1; imm = 32'hA1; out_ready = 0;
    step(); imm = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      check_val("bp_rdy", {31'd0, in_ready}, 32'd0);
      check_val("bp_hold", alu_in2, 32'hA1);
      step();
    end
    out_ready = 1;
    step(); in_valid = 0;
    check_val("b2b_valid", {31'd0, out_valid}, 32'd1);
    check_val("b2b_val", alu_in2, 32'hB2);
    step();

    // Flush during WAIT.
    quiet(); in_valid = 1; rs2_addr = 9; fwd_valid = 2'b10; fwd_pending = 2'b10;
    fwd_rd = {5'd9, 5'd0};
    step(); in_valid = 0; flush = 1;
    step(); flush = 0; fwd_pending = 0;
    for (int i = 0; i < 2; i++) begin
      check_val("flush_valid", {31'd0, out_valid}, 32'd0);
      step();
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) < 2);
      flush       = ($urandom_range(0, 99) < 4);
      in_valid    = ($urandom_range(0, 99) < 70);
      out_ready   = ($urandom_range(0, 99) < 70);
      alu2_sel    = ($urandom_range(0, 99) < 25);
      rs2_addr    = 5'($urandom_range(0, 3));
      rs2_d       = $urandom;
      imm         = $urandom;
      fwd_valid   = 2'($urandom_range(0, 3));
      fwd_pending = ($urandom_range(0, 99) < 40) ? 2'($urandom_range(0, 3)) : 2'b00;
      fwd_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_data    = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
